// File: rtl/alu_issue_sequencer.sv
// ALU issue sequencer: turns decoded A-type instructions into EX-stage micro-ops.
// SWAP is split into two register-to-register micro-ops; flush discards anything held.
module alu_issue_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  ALUOP,
   input  logic [3:0]  FunctionCode,
   input  logic [3:0]  Rd,
   input  logic [3:0]  Rs,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  ALUControl,
   output logic [3:0]  DestReg,
   output logic [3:0]  SrcReg,
   output logic        RegWrite,
   output logic        UopIdx,
   output logic        IllegalOp,
   output logic [15:0] UopCount
);

   // state  | meaning
   // EMPTY  | nothing held, ready for a new instruction
   // ISSUE  | single micro-op or second SWAP micro-op held
   // SWAP_A | first SWAP micro-op held, second still pending
   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      ISSUE  = 2'd1,
      SWAP_A = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic       accept;
   logic       fire;
   logic       is_atype;
   logic       is_swap;
   logic       is_illegal;
   logic [2:0] dec_ctrl;
   logic       dec_write;

   assign in_ready  = !flush && ((state == EMPTY) || ((state == ISSUE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state != EMPTY);
   assign fire      = out_valid && out_ready && !flush;
   assign is_atype  = (ALUOP == 4'b0001);

   always_comb begin
      dec_ctrl   = 3'b000;
      dec_write  = 1'b0;
      is_swap    = 1'b0;
      is_illegal = 1'b0;
      if (is_atype) begin
         case (FunctionCode)
            4'b0000: begin dec_ctrl = 3'b000; dec_write = 1'b1; end
            4'b0001: begin dec_ctrl = 3'b001; dec_write = 1'b1; end
            4'b1110: begin dec_ctrl = 3'b010; dec_write = 1'b1; end
            4'b1111: begin dec_ctrl = 3'b011; dec_write = 1'b1; is_swap = 1'b1; end
            default: begin dec_ctrl = 3'b011; dec_write = 1'b0; is_illegal = 1'b1; end
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) state_nxt = is_swap ? SWAP_A : ISSUE;
            end
            ISSUE: begin
               if (out_ready) begin
                  if (in_valid) state_nxt = is_swap ? SWAP_A : ISSUE;
                  else          state_nxt = EMPTY;
               end
            end
            SWAP_A: begin
               if (out_ready) state_nxt = ISSUE;
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         ALUControl <= 3'b000;
         DestReg    <= 4'd0;
         SrcReg     <= 4'd0;
         RegWrite   <= 1'b0;
         UopIdx     <= 1'b0;
         IllegalOp  <= 1'b0;
         UopCount   <= 16'd0;
      end else begin
         state     <= state_nxt;
         IllegalOp <= accept && is_illegal;
         if (fire) UopCount <= UopCount + 16'd1;
         if (accept) begin
            ALUControl <= dec_ctrl;
            DestReg    <= Rd;
            SrcReg     <= Rs;
            RegWrite   <= dec_write;
            UopIdx     <= 1'b0;
         end else if ((state == SWAP_A) && out_ready && !flush) begin
            // second SWAP micro-op writes the original source with the original destination
            DestReg <= SrcReg;
            SrcReg  <= DestReg;
            UopIdx  <= 1'b1;
         end
      end
   end

endmodule
